trap_controller: RTL and testbench

- Initiator side of the core's context-switch interface: collects synchronous exceptions from the pipeline and asynchronous external interrupt lines, prioritises them, and issues a one-cycle CS request with CAUSE and saved PC to the CSR file.
- Holds the pipeline until the CSR file acknowledges with DE_CS.
- Sits between the execute/retire stage and the CSR file.

---
 rtl/trap_pkg.sv | 37 +++
 rtl/trap_controller_if.sv | 36 +++
 rtl/trap_controller_irq_sync_edge.sv | 35 +++
 rtl/trap_controller.sv | 149 ++++++++++++++
 tb/tb_trap_controller.sv | 391 +++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/trap_pkg.sv
// Shared types and constants for the trap controller: FSM state encoding,
// CAUSE layout and the standard synchronous exception codes.
package trap_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_ISSUE    = 2'd1,
    ST_WAIT_ACK = 2'd2
  } trap_state_t;

  // Low CAUSE bits that carry the exception / interrupt code
  localparam int CAUSE_CODE_W = 13;

  // Standard synchronous exception cause codes
  localparam logic [5:0] EXC_INSTR_MISALIGNED = 6'd0;
  localparam logic [5:0] EXC_INSTR_FAULT      = 6'd1;
  localparam logic [5:0] EXC_ILLEGAL_INSTR    = 6'd2;
  localparam logic [5:0] EXC_BREAKPOINT       = 6'd3;
  localparam logic [5:0] EXC_LOAD_MISALIGNED  = 6'd4;
  localparam logic [5:0] EXC_LOAD_FAULT       = 6'd5;
  localparam logic [5:0] EXC_STORE_MISALIGNED = 6'd6;
  localparam logic [5:0] EXC_STORE_FAULT      = 6'd7;
  localparam logic [5:0] EXC_ECALL_U          = 6'd8;
  localparam logic [5:0] EXC_ECALL_S          = 6'd9;
  localparam logic [5:0] EXC_ECALL_M          = 6'd11;

  // Interrupt flag position inside CAUSE (the MSB of an XLEN-wide word)
  function automatic int cause_int_bit(input int xlen);
    return xlen - 1;
  endfunction

  // Cause code reported for external interrupt line idx
  function automatic logic [CAUSE_CODE_W-1:0] irq_code(input int base, input int idx);
    return CAUSE_CODE_W'(base + idx);
  endfunction

endpackage

// File: rtl/trap_controller_if.sv
// Pipeline / CSR-file facing signal bundle of the trap controller.
// master: the trap controller itself; slave: the pipeline and CSR side.
interface trap_controller_if #(
  parameter int XLEN    = 64,
  parameter int NUM_IRQ = 8
);
  logic               i_exc_valid;
  logic [5:0]         i_exc_code;
  logic [XLEN-1:0]    i_exc_pc;
  logic [XLEN-1:0]    i_npc;
  logic               i_instr_boundary;
  logic [NUM_IRQ-1:0] i_irq;
  logic [NUM_IRQ-1:0] i_irq_en;
  logic               i_gie;
  logic               i_de_cs;

  logic               o_cs;
  logic [XLEN-1:0]    o_cause;
  logic [XLEN-1:0]    o_trap_pc;
  logic               o_stall;
  logic               o_flush;
  logic [NUM_IRQ-1:0] o_irq_pending;
  logic               o_ack_err;

  modport master (
    input  i_exc_valid, i_exc_code, i_exc_pc, i_npc, i_instr_boundary,
           i_irq, i_irq_en, i_gie, i_de_cs,
    output o_cs, o_cause, o_trap_pc, o_stall, o_flush, o_irq_pending, o_ack_err
  );

  modport slave (
    output i_exc_valid, i_exc_code, i_exc_pc, i_npc, i_instr_boundary,
           i_irq, i_irq_en, i_gie, i_de_cs,
    input  o_cs, o_cause, o_trap_pc, o_stall, o_flush, o_irq_pending, o_ack_err
  );
endinterface

// File: rtl/trap_controller_irq_sync_edge.sv
// One external interrupt line: two-flop synchronizer, rising-edge detect
// against a delayed copy, and the sticky pending bit. A fresh edge beats a
// simultaneous clear so no interrupt is ever lost.
module irq_sync_edge (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_irq,
  input  logic i_clr,
  output logic o_pending
);
  logic r_sync1;
  logic r_sync2;
  logic r_dly;
  logic r_pending;
  logic w_rise;

  assign w_rise = r_sync2 & ~r_dly;

  // Synchronize the line, keep a delayed copy, and set/clear the pending bit
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_sync1   <= 1'b0;
      r_sync2   <= 1'b0;
      r_dly     <= 1'b0;
      r_pending <= 1'b0;
    end else begin
      r_sync1   <= i_irq;
      r_sync2   <= r_sync1;
      r_dly     <= r_sync2;
      r_pending <= w_rise | (r_pending & ~i_clr);
    end
  end

  assign o_pending = r_pending;
endmodule

// File: rtl/trap_controller.sv
// Trap controller: collects synchronous exceptions and external interrupts,
// picks one (exception first, then lowest-index enabled interrupt), issues a
// one-cycle CS/FLUSH with CAUSE and TRAP_PC, and stalls the pipeline until
// the CSR file acknowledges with DE_CS or the acknowledge window expires.
module trap_controller
  import trap_pkg::*;
#(
  parameter int XLEN          = 64,
  parameter int NUM_IRQ       = 8,
  parameter int IRQ_CODE_BASE = 16,
  parameter int ACK_TIMEOUT   = 15
) (
  input logic              i_clk,
  input logic              i_rst,
  trap_controller_if.master bus
);
  localparam int IDX_W   = (NUM_IRQ > 1) ? $clog2(NUM_IRQ) : 1;
  localparam int INT_BIT = cause_int_bit(XLEN);

  trap_state_t       r_state;
  logic              r_cs;
  logic              r_flush;
  logic              r_stall;
  logic              r_ack_err;
  logic [XLEN-1:0]   r_cause;
  logic [XLEN-1:0]   r_trap_pc;
  logic              r_is_irq;
  logic [IDX_W-1:0]  r_idx;
  logic [7:0]        r_cnt;

  logic [NUM_IRQ-1:0] w_pending;
  logic [NUM_IRQ-1:0] w_masked;
  logic [NUM_IRQ-1:0] w_clr;
  logic               w_irq_hit;
  logic [IDX_W-1:0]   w_irq_idx;
  logic               w_irq_take;
  logic               w_ack_irq;
  logic [XLEN-1:0]    w_irq_cause;
  logic [XLEN-1:0]    w_exc_cause;

  // An acknowledged interrupt trap retires exactly the line it captured
  assign w_ack_irq = (r_state == ST_WAIT_ACK) & bus.i_de_cs & r_is_irq;

  for (genvar g = 0; g < NUM_IRQ; g++) begin : g_irq
    assign w_clr[g] = w_ack_irq & (r_idx == IDX_W'(g));

    irq_sync_edge u_sync (
      .i_clk     (i_clk),
      .i_rst     (i_rst),
      .i_irq     (bus.i_irq[g]),
      .i_clr     (w_clr[g]),
      .o_pending (w_pending[g])
    );
  end

  assign w_masked = w_pending & bus.i_irq_en;

  // Priority encoder: scan from the top so the lowest pending index wins
  always_comb begin
    w_irq_hit = 1'b0;
    w_irq_idx = '0;
    for (int i = NUM_IRQ - 1; i >= 0; i--) begin
      if (w_masked[i]) begin
        w_irq_hit = 1'b1;
        w_irq_idx = IDX_W'(i);
      end
    end
  end

  assign w_irq_take  = bus.i_gie & bus.i_instr_boundary & w_irq_hit;
  assign w_exc_cause = XLEN'(bus.i_exc_code);

  // Interrupt CAUSE: flag in the MSB, base-offset code in the low bits
  always_comb begin
    w_irq_cause                     = '0;
    w_irq_cause[INT_BIT]            = 1'b1;
    w_irq_cause[CAUSE_CODE_W-1:0]   = irq_code(IRQ_CODE_BASE, int'(w_irq_idx));
  end

  // Trap FSM with registered CS/FLUSH/STALL, capture registers and ack timer
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state   <= ST_IDLE;
      r_cs      <= 1'b0;
      r_flush   <= 1'b0;
      r_stall   <= 1'b0;
      r_ack_err <= 1'b0;
      r_cause   <= '0;
      r_trap_pc <= '0;
      r_is_irq  <= 1'b0;
      r_idx     <= '0;
      r_cnt     <= '0;
    end else begin
      r_cs    <= 1'b0;
      r_flush <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (bus.i_exc_valid) begin
            r_cause   <= w_exc_cause;
            r_trap_pc <= bus.i_exc_pc;
            r_is_irq  <= 1'b0;
            r_state   <= ST_ISSUE;
            r_cs      <= 1'b1;
            r_flush   <= 1'b1;
            r_stall   <= 1'b1;
          end else if (w_irq_take) begin
            r_cause   <= w_irq_cause;
            r_trap_pc <= bus.i_npc;
            r_is_irq  <= 1'b1;
            r_idx     <= w_irq_idx;
            r_state   <= ST_ISSUE;
            r_cs      <= 1'b1;
            r_flush   <= 1'b1;
            r_stall   <= 1'b1;
          end
        end
        ST_ISSUE: begin
          r_state <= ST_WAIT_ACK;
          r_cnt   <= '0;
        end
        ST_WAIT_ACK: begin
          if (bus.i_de_cs) begin
            r_state <= ST_IDLE;
            r_stall <= 1'b0;
          end else if (r_cnt == 8'(ACK_TIMEOUT - 1)) begin
            // Give up; the pending bit is kept so the trap is retried
            r_ack_err <= 1'b1;
            r_state   <= ST_IDLE;
            r_stall   <= 1'b0;
          end else begin
            r_cnt <= r_cnt + 8'd1;
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_stall <= 1'b0;
        end
      endcase
    end
  end

  assign bus.o_cs          = r_cs;
  assign bus.o_flush       = r_flush;
  assign bus.o_stall       = r_stall;
  assign bus.o_ack_err     = r_ack_err;
  assign bus.o_cause       = r_cause;
  assign bus.o_trap_pc     = r_trap_pc;
  assign bus.o_irq_pending = w_pending;
endmodule

// File: tb/tb_trap_controller.sv
// Testbench for trap_controller: directed scenarios plus a randomized run,
// all checked against a transaction-level reference model of the trap rules.
module tb_trap_controller;
  import trap_pkg::*;

  localparam int XLEN          = 64;
  localparam int NUM_IRQ       = 8;
  localparam int IRQ_CODE_BASE = 16;
  localparam int ACK_TIMEOUT   = 15;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  trap_controller_if #(.XLEN(XLEN), .NUM_IRQ(NUM_IRQ)) bus ();

  trap_controller #(
    .XLEN(XLEN), .NUM_IRQ(NUM_IRQ),
    .IRQ_CODE_BASE(IRQ_CODE_BASE), .ACK_TIMEOUT(ACK_TIMEOUT)
  ) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // ---------------- reference model ----------------
  int               m_edge;
  bit               m_prev [NUM_IRQ];
  int               m_setq [NUM_IRQ][$];   // edge numbers at which pending becomes visible
  logic [NUM_IRQ-1:0] m_pend;
  int               m_mode;                // 0 idle, 1 issuing, 2 awaiting ack
  int               m_wait;                // cycles spent awaiting ack
  logic [XLEN-1:0]  m_cause, m_pc;
  bit               m_ack_err;
  bit               m_irq_trap;
  int               m_idx;

  function automatic void model_reset();
    for (int i = 0; i < NUM_IRQ; i++) begin
      m_prev[i] = 1'b0;
      m_setq[i].delete();
    end
    m_pend = '0; m_mode = 0; m_wait = 0;
    m_cause = '0; m_pc = '0; m_ack_err = 1'b0; m_irq_trap = 1'b0; m_idx = 0;
  endfunction

  // Predict state after the coming rising edge from the inputs now applied
  function automatic void model_step();
    logic [NUM_IRQ-1:0] np;
    int lowest;
    if (rst) begin
      model_reset();
      return;
    end
    m_edge++;
    np = m_pend;
    if (m_mode == 2 && bus.i_de_cs && m_irq_trap) np[m_idx] = 1'b0;
    for (int i = 0; i < NUM_IRQ; i++) begin
      if (bus.i_irq[i] && !m_prev[i]) m_setq[i].push_back(m_edge + 2);
      m_prev[i] = bus.i_irq[i];
      while (m_setq[i].size() > 0 && m_setq[i][0] == m_edge) begin
        np[i] = 1'b1;
        void'(m_setq[i].pop_front());
      end
    end
    case (m_mode)
      0: begin
        lowest = -1;
        for (int i = 0; i < NUM_IRQ; i++)
          if (lowest < 0 && m_pend[i] && bus.i_irq_en[i]) lowest = i;
        if (bus.i_exc_valid) begin
          m_mode = 1; m_cause = XLEN'(bus.i_exc_code); m_pc = bus.i_exc_pc; m_irq_trap = 1'b0;
        end else if (bus.i_gie && bus.i_instr_boundary && lowest >= 0) begin
          m_mode = 1;
          m_cause = (XLEN'(1) << (XLEN - 1)) | XLEN'(IRQ_CODE_BASE + lowest);
          m_pc = bus.i_npc; m_irq_trap = 1'b1; m_idx = lowest;
        end
      end
      1: begin m_mode = 2; m_wait = 0; end
      default: begin
        m_wait++;
        if (bus.i_de_cs) m_mode = 0;
        else if (m_wait == ACK_TIMEOUT) begin m_ack_err = 1'b1; m_mode = 0; end
      end
    endcase
    m_pend = np;
  endfunction

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic ack();
    tick();
    bus.i_de_cs = 1'b1;
    tick();
    bus.i_de_cs = 1'b0;
  endtask

  task automatic idle_inputs();
    bus.i_exc_valid = 1'b0; bus.i_exc_code = '0; bus.i_exc_pc = '0; bus.i_npc = '0;
    bus.i_instr_boundary = 1'b1; bus.i_irq = '0; bus.i_irq_en = '0;
    bus.i_gie = 1'b0; bus.i_de_cs = 1'b0;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst = 1'b1;
    idle_inputs();
    tick(); tick();
    n_cmp++;
    if ({bus.o_cs, bus.o_flush, bus.o_stall, bus.o_ack_err} !== 4'b0000) begin
      n_bad++; $display("FAIL reset_ctrl: got %b want 0000", {bus.o_cs, bus.o_flush, bus.o_stall, bus.o_ack_err});
    end
    n_cmp++;
    if (bus.o_irq_pending !== '0) begin
      n_bad++; $display("FAIL reset_pending: got %h want 0", bus.o_irq_pending);
    end
    n_cmp++;
    if (bus.o_cause !== '0 || bus.o_trap_pc !== '0) begin
      n_bad++; $display("FAIL reset_cause_pc: got %h/%h want 0/0", bus.o_cause, bus.o_trap_pc);
    end
    rst = 1'b0;
    tick();
    n_cmp++;
    if (bus.o_stall !== 1'b0) begin
      n_bad++; $display("FAIL reset_release_stall: got %b want 0", bus.o_stall);
    end
  endtask

  task automatic test_exception();
    bus.i_exc_valid = 1'b1; bus.i_exc_code = EXC_ILLEGAL_INSTR; bus.i_exc_pc = 64'h1000;
    tick();
    bus.i_exc_valid = 1'b0;
    n_cmp++;
    if ({bus.o_cs, bus.o_flush, bus.o_stall} !== 3'b111) begin
      n_bad++; $display("FAIL exc_issue: cs/flush/stall got %b want 111", {bus.o_cs, bus.o_flush, bus.o_stall});
    end
    n_cmp++;
    if (bus.o_cause !== 64'h2 || bus.o_trap_pc !== 64'h1000) begin
      n_bad++; $display("FAIL exc_cause_pc: got %h/%h want 2/1000", bus.o_cause, bus.o_trap_pc);
    end
    tick();
    n_cmp++;
    if ({bus.o_cs, bus.o_flush, bus.o_stall} !== 3'b001) begin
      n_bad++; $display("FAIL exc_wait: cs/flush/stall got %b want 001", {bus.o_cs, bus.o_flush, bus.o_stall});
    end
    ack();
    n_cmp++;
    if (bus.o_stall !== 1'b0 || bus.o_cause !== 64'h2) begin
      n_bad++; $display("FAIL exc_ack: stall/cause got %b/%h want 0/2", bus.o_stall, bus.o_cause);
    end
  endtask

  task automatic test_interrupt();
    bus.i_gie = 1'b1; bus.i_irq_en = 8'h08; bus.i_instr_boundary = 1'b1; bus.i_npc = 64'h2004;
    bus.i_irq[3] = 1'b1;
    tick(); tick();
    n_cmp++;
    if (bus.o_irq_pending !== 8'h00) begin
      n_bad++; $display("FAIL irq_pending_early: got %h want 00", bus.o_irq_pending);
    end
    tick();
    n_cmp++;
    if (bus.o_irq_pending !== 8'h08 || bus.o_cs !== 1'b0) begin
      n_bad++; $display("FAIL irq_pending_set: pending/cs got %h/%b want 08/0", bus.o_irq_pending, bus.o_cs);
    end
    tick();
    n_cmp++;
    if (bus.o_cs !== 1'b1 || bus.o_cause !== 64'h8000_0000_0000_0013 || bus.o_trap_pc !== 64'h2004) begin
      n_bad++; $display("FAIL irq_issue: cs/cause/pc got %b/%h/%h want 1/8000000000000013/2004",
                        bus.o_cs, bus.o_cause, bus.o_trap_pc);
    end
    ack();
    n_cmp++;
    if (bus.o_irq_pending !== 8'h00 || bus.o_stall !== 1'b0) begin
      n_bad++; $display("FAIL irq_ack_clear: pending/stall got %h/%b want 00/0", bus.o_irq_pending, bus.o_stall);
    end
    bus.i_irq = '0;
  endtask

  task automatic test_priority();
    bus.i_gie = 1'b0; bus.i_irq_en = 8'hFF;
    bus.i_irq[5] = 1'b1; bus.i_irq[1] = 1'b1;
    tick(); tick(); tick();
    n_cmp++;
    if (bus.o_irq_pending !== 8'h22) begin
      n_bad++; $display("FAIL prio_pending: got %h want 22", bus.o_irq_pending);
    end
    bus.i_gie = 1'b1;
    tick();
    n_cmp++;
    if (bus.o_cs !== 1'b1 || bus.o_cause[12:0] !== 13'd17) begin
      n_bad++; $display("FAIL prio_first: cs/code got %b/%0d want 1/17", bus.o_cs, bus.o_cause[12:0]);
    end
    ack();
    n_cmp++;
    if (bus.o_irq_pending !== 8'h20) begin
      n_bad++; $display("FAIL prio_after_first: got %h want 20", bus.o_irq_pending);
    end
    tick();
    n_cmp++;
    if (bus.o_cs !== 1'b1 || bus.o_cause[12:0] !== 13'd21) begin
      n_bad++; $display("FAIL prio_second: cs/code got %b/%0d want 1/21", bus.o_cs, bus.o_cause[12:0]);
    end
    ack();
    bus.i_irq = '0;
  endtask

  task automatic test_masking();
    int k;
    bus.i_gie = 1'b1; bus.i_irq_en = 8'h00;
    bus.i_irq[2] = 1'b1;
    for (int i = 0; i < 4; i++) tick();
    n_cmp++;
    if (bus.o_irq_pending !== 8'h04 || bus.o_stall !== 1'b0) begin
      n_bad++; $display("FAIL mask_en: pending/stall got %h/%b want 04/0", bus.o_irq_pending, bus.o_stall);
    end
    bus.i_gie = 1'b0; bus.i_irq_en = 8'h04;
    tick(); tick();
    n_cmp++;
    if (bus.o_stall !== 1'b0) begin
      n_bad++; $display("FAIL mask_gie: stall got %b want 0", bus.o_stall);
    end
    bus.i_gie = 1'b1;
    k = 0;
    while (k < 2 && bus.o_cs !== 1'b1) begin tick(); k++; end
    n_cmp++;
    if (bus.o_cs !== 1'b1 || bus.o_cause[12:0] !== 13'd18) begin
      n_bad++; $display("FAIL mask_unmask: cs/code got %b/%0d want 1/18 within 2 cycles", bus.o_cs, bus.o_cause[12:0]);
    end
    ack();
    bus.i_irq = '0;
  endtask

  task automatic test_collision();
    bus.i_gie = 1'b1; bus.i_irq_en = 8'h40; bus.i_instr_boundary = 1'b1;
    bus.i_irq[6] = 1'b1;
    tick(); tick(); tick();
    bus.i_exc_valid = 1'b1; bus.i_exc_code = EXC_ECALL_M; bus.i_exc_pc = 64'h3000;
    tick();
    bus.i_exc_valid = 1'b0;
    n_cmp++;
    if (bus.o_cs !== 1'b1 || bus.o_cause !== 64'd11 || bus.o_irq_pending !== 8'h40) begin
      n_bad++; $display("FAIL coll_exc_wins: cs/cause/pending got %b/%h/%h want 1/b/40",
                        bus.o_cs, bus.o_cause, bus.o_irq_pending);
    end
    ack();
    n_cmp++;
    if (bus.o_irq_pending !== 8'h40) begin
      n_bad++; $display("FAIL coll_still_pending: got %h want 40", bus.o_irq_pending);
    end
    tick();
    n_cmp++;
    if (bus.o_cs !== 1'b1 || bus.o_cause[63] !== 1'b1 || bus.o_cause[12:0] !== 13'd22) begin
      n_bad++; $display("FAIL coll_irq_next: cs/cause got %b/%h want 1/irq code 22", bus.o_cs, bus.o_cause);
    end
    ack();
    bus.i_irq = '0;
  endtask

  task automatic test_timeout();
    int k;
    bus.i_gie = 1'b1; bus.i_irq_en = 8'h01; bus.i_instr_boundary = 1'b1;
    bus.i_irq[0] = 1'b1;
    k = 0;
    while (k < 6 && bus.o_cs !== 1'b1) begin tick(); k++; end
    n_cmp++;
    if (bus.o_cs !== 1'b1) begin
      n_bad++; $display("FAIL tmo_issue: cs got %b want 1 within 6 cycles", bus.o_cs);
    end
    for (int i = 0; i < ACK_TIMEOUT; i++) tick();
    n_cmp++;
    if (bus.o_stall !== 1'b1 || bus.o_ack_err !== 1'b0) begin
      n_bad++; $display("FAIL tmo_before: stall/ack_err got %b/%b want 1/0", bus.o_stall, bus.o_ack_err);
    end
    tick();
    n_cmp++;
    if (bus.o_stall !== 1'b0 || bus.o_ack_err !== 1'b1 || bus.o_irq_pending !== 8'h01) begin
      n_bad++; $display("FAIL tmo_expire: stall/ack_err/pending got %b/%b/%h want 0/1/01",
                        bus.o_stall, bus.o_ack_err, bus.o_irq_pending);
    end
    tick();
    n_cmp++;
    if (bus.o_cs !== 1'b1 || bus.o_cause[12:0] !== 13'd16) begin
      n_bad++; $display("FAIL tmo_reissue: cs/code got %b/%0d want 1/16", bus.o_cs, bus.o_cause[12:0]);
    end
    ack();
    n_cmp++;
    if (bus.o_irq_pending !== 8'h00 || bus.o_ack_err !== 1'b1) begin
      n_bad++; $display("FAIL tmo_sticky: pending/ack_err got %h/%b want 00/1", bus.o_irq_pending, bus.o_ack_err);
    end
    bus.i_irq = '0;
  endtask

  task automatic test_reset_in_wait();
    int k;
    bus.i_gie = 1'b1; bus.i_irq_en = 8'h10;
    bus.i_irq[4] = 1'b1;
    k = 0;
    while (k < 6 && bus.o_cs !== 1'b1) begin tick(); k++; end
    tick();
    n_cmp++;
    if (bus.o_stall !== 1'b1 || bus.o_irq_pending !== 8'h10) begin
      n_bad++; $display("FAIL rstw_pre: stall/pending got %b/%h want 1/10", bus.o_stall, bus.o_irq_pending);
    end
    #2;
    rst = 1'b1;
    bus.i_irq = '0;
    #1;
    model_reset();
    n_cmp++;
    if ({bus.o_cs, bus.o_stall, bus.o_ack_err} !== 3'b000 || bus.o_irq_pending !== '0) begin
      n_bad++; $display("FAIL rstw_async_ctrl: cs/stall/ack_err/pending got %b/%h want 000/00",
                        {bus.o_cs, bus.o_stall, bus.o_ack_err}, bus.o_irq_pending);
    end
    n_cmp++;
    if (bus.o_cause !== '0 || bus.o_trap_pc !== '0) begin
      n_bad++; $display("FAIL rstw_async_data: cause/pc got %h/%h want 0/0", bus.o_cause, bus.o_trap_pc);
    end
    tick();
    rst = 1'b0;
    bus.i_de_cs = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_cmp++;
      if ({bus.o_cs, bus.o_stall, bus.o_ack_err} !== 3'b000) begin
        n_bad++; $display("FAIL rstw_late_ack: cs/stall/ack_err got %b want 000", {bus.o_cs, bus.o_stall, bus.o_ack_err});
      end
    end
    bus.i_de_cs = 1'b0;
  endtask

  task automatic test_random();
    logic [2*XLEN+NUM_IRQ+3:0] obs, exp;
    int slow_ack;
    slow_ack = 0;
    bus.i_irq_en = 8'hFF;
    for (int c = 0; c < 2000; c++) begin
      if (c % 200 == 0) slow_ack = $urandom_range(0, 1);
      bus.i_exc_valid      = ($urandom_range(0, 7) == 0);
      bus.i_exc_code       = 6'($urandom);
      bus.i_exc_pc         = {$urandom, $urandom};
      bus.i_npc            = {$urandom, $urandom};
      bus.i_instr_boundary = ($urandom_range(0, 3) != 0);
      bus.i_gie            = ($urandom_range(0, 7) != 0);
      if ($urandom_range(0, 49) == 0) bus.i_irq_en = 8'($urandom);
      for (int i = 0; i < NUM_IRQ; i++)
        if ($urandom_range(0, 15) == 0) bus.i_irq[i] = ~bus.i_irq[i];
      bus.i_de_cs = slow_ack ? ($urandom_range(0, 19) == 0) : ($urandom_range(0, 1) == 0);
      tick();
      obs = {bus.o_cs, bus.o_flush, bus.o_stall, bus.o_ack_err, bus.o_irq_pending, bus.o_cause, bus.o_trap_pc};
      exp = {(m_mode == 1), (m_mode == 1), (m_mode != 0), m_ack_err, m_pend, m_cause, m_pc};
      n_cmp++;
      if (obs !== exp) begin
        n_bad++;
        $display("FAIL random_cycle_%0d: {cs,flush,stall,err,pend,cause,pc} got %h want %h", c, obs, exp);
      end
    end
    idle_inputs();
  endtask

  initial begin
    rst = 1'b1;
    m_edge = 0;
    idle_inputs();
    model_reset();
    test_reset();
    test_exception();
    test_interrupt();
    test_priority();
    test_masking();
    test_collision();
    test_timeout();
    test_reset_in_wait();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end
endmodule
